// File: rtl/two_digit_display_pkg.sv
// Shared types and constants for the two-digit
// multiplexed seven-segment display stage.
package two_digit_display_pkg;

  typedef enum logic [1:0] {
    BLANK_0 = 2'd0,
    SHOW_0  = 2'd1,
    BLANK_1 = 2'd2,
    SHOW_1  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [3:0] AN_ONES   = 4'b1110;
  localparam logic [3:0] AN_TENS   = 4'b1101;

endpackage

// File: rtl/two_digit_display_bcd_to_seg7.sv
// Combinational BCD to active-low {g..a} decoder;
// codes 10-15 render as a dash.
module bcd_to_seg7
  import two_digit_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/two_digit_display.sv
// Time-multiplexes two BCD digits onto a 4-anode
// common-anode display with blanking between digits.
module two_digit_display
  import two_digit_display_pkg::*;
#(
  parameter int REFRESH_DIV        = 100000,
  parameter int BLANK_CYCLES       = 16,
  parameter int LEADING_ZERO_BLANK = 1
) (
  input  logic       two_digit_display_clk,
  input  logic       two_digit_display_rst,
  input  logic [3:0] two_digit_display_first_num,
  input  logic [3:0] two_digit_display_second_num,
  output logic [3:0] two_digit_display_an,
  output logic [6:0] two_digit_display_seg,
  output logic       two_digit_display_dp
);

  localparam int MAXC =
    (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LD  = CW'(REFRESH_DIV - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [3:0]    digit_q;
  logic [3:0]    dec_in;
  logic [6:0]    dec_seg;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          adv;
  logic          to_show;
  logic          lz_off;

  assign adv     = (cnt == '0);
  assign to_show = adv &&
                   (state == BLANK_0 || state == BLANK_1);

  // Digit is captured only on entry to a SHOW state.
  assign dec_in = !to_show ? digit_q :
                  (state == BLANK_0) ?
                  two_digit_display_first_num :
                  two_digit_display_second_num;

  assign lz_off = (LEADING_ZERO_BLANK != 0) &&
                  (state == BLANK_1) &&
                  (two_digit_display_second_num == 4'd0);

  always_comb begin
    state_n = state;
    case (state)
      BLANK_0: state_n = SHOW_0;
      SHOW_0:  state_n = BLANK_1;
      BLANK_1: state_n = SHOW_1;
      SHOW_1:  state_n = BLANK_0;
      default: state_n = BLANK_0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .code (dec_in),
    .seg  (dec_seg)
  );

  always_ff @(posedge two_digit_display_clk or
              negedge two_digit_display_rst) begin
    if (!two_digit_display_rst) begin
      state   <= BLANK_0;
      cnt     <= BLANK_LD;
      digit_q <= 4'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else if (adv) begin
      state <= state_n;
      if (to_show) begin
        cnt     <= SHOW_LD;
        digit_q <= dec_in;
        if (lz_off) begin
          an_q  <= AN_OFF;
          seg_q <= SEG_BLANK;
        end else begin
          an_q  <= (state == BLANK_0) ? AN_ONES : AN_TENS;
          seg_q <= dec_seg;
        end
      end else begin
        cnt   <= BLANK_LD;
        an_q  <= AN_OFF;
        seg_q <= SEG_BLANK;
      end
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign two_digit_display_an  = an_q;
  assign two_digit_display_seg = seg_q;
  assign two_digit_display_dp  = 1'b1;

endmodule

// File: tb/tb_two_digit_display.sv
// Scoreboard bench for two_digit_display with
// REFRESH_DIV=4, BLANK_CYCLES=2 (12-cycle period).
module tb_two_digit_display;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S6   = 7'b0000010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BLK  = 7'b1111111;
  localparam logic [3:0] OFF  = 4'b1111;
  localparam logic [3:0] A0   = 4'b1110;
  localparam logic [3:0] A1   = 4'b1101;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] an_z;
    logic [6:0] seg_z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] first = 4'd0;
  logic [3:0] second = 4'd0;
  logic [3:0] an, an_z;
  logic [6:0] seg, seg_z;
  logic       dp, dp_z;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  two_digit_display #(
    .REFRESH_DIV(4), .BLANK_CYCLES(2), .LEADING_ZERO_BLANK(1)
  ) dut (
    .two_digit_display_clk        (clk),
    .two_digit_display_rst        (rst_n),
    .two_digit_display_first_num  (first),
    .two_digit_display_second_num (second),
    .two_digit_display_an         (an),
    .two_digit_display_seg        (seg),
    .two_digit_display_dp         (dp)
  );

  two_digit_display #(
    .REFRESH_DIV(4), .BLANK_CYCLES(2), .LEADING_ZERO_BLANK(0)
  ) dut_z (
    .two_digit_display_clk        (clk),
    .two_digit_display_rst        (rst_n),
    .two_digit_display_first_num  (first),
    .two_digit_display_second_num (second),
    .two_digit_display_an         (an_z),
    .two_digit_display_seg        (seg_z),
    .two_digit_display_dp         (dp_z)
  );

  task automatic push_n(input logic [3:0] a, input logic [6:0] s,
                        input logic [3:0] az, input logic [6:0] sz,
                        input int n);
    for (int i = 0; i < n; i++) q.push_back('{a, s, az, sz});
  endtask

  // One period starting at SHOW_0: 4 show, 2 blank, 4 show, 2 blank.
  task automatic push_period(input logic [6:0] s0,
                             input logic [3:0] a1, input logic [6:0] s1,
                             input logic [3:0] a1z, input logic [6:0] s1z);
    push_n(A0, s0, A0, s0, 4);
    push_n(OFF, BLK, OFF, BLK, 2);
    push_n(a1, s1, a1z, s1z, 4);
    push_n(OFF, BLK, OFF, BLK, 2);
  endtask

  task automatic restart(input logic [3:0] f, input logic [3:0] s);
    @(negedge clk);
    rst_n = 1'b0;
    first = f;
    second = s;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1 rst_n = 1'b0;
    first = 4'd7;
    second = 4'd4;
    #1;
    checks++;
    if ({an, seg, dp, an_z, seg_z, dp_z} !==
        {OFF, BLK, 1'b1, OFF, BLK, 1'b1}) begin
      failures++;
      $display("FAIL reset_async an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
               an, seg, dp, OFF, BLK);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_n(OFF, BLK, OFF, BLK, 1);
    push_period(S7, A1, S4, A1, S4);
    push_period(S7, A1, S4, A1, S4);
    for (int k = 1; q.size() > 0; k++) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if ({an, seg, dp, an_z, seg_z, dp_z} !==
          {e.an, e.seg, 1'b1, e.an_z, e.seg_z, 1'b1}) begin
        failures++;
        $display("FAIL reset_seq cyc=%0d got an=%b seg=%b an_z=%b seg_z=%b dp=%b want an=%b seg=%b an_z=%b seg_z=%b",
                 k, an, seg, an_z, seg_z, dp, e.an, e.seg, e.an_z, e.seg_z);
      end
    end
  endtask

  task automatic test_leading_zero;
    restart(4'd8, 4'd0);
    push_n(OFF, BLK, OFF, BLK, 1);
    push_period(S8, OFF, BLK, A1, S0);
    push_period(S8, OFF, BLK, A1, S0);
    for (int k = 1; q.size() > 0; k++) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if ({an, seg, an_z, seg_z} !== {e.an, e.seg, e.an_z, e.seg_z}) begin
        failures++;
        $display("FAIL leading_zero cyc=%0d got an=%b seg=%b an_z=%b seg_z=%b want an=%b seg=%b an_z=%b seg_z=%b",
                 k, an, seg, an_z, seg_z, e.an, e.seg, e.an_z, e.seg_z);
      end
    end
  endtask

  task automatic test_no_tear;
    restart(4'd3, 4'd1);
    push_n(OFF, BLK, OFF, BLK, 1);
    push_period(S3, A1, S1, A1, S1);
    push_period(S5, A1, S1, A1, S1);
    for (int k = 1; q.size() > 0; k++) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if ({an, seg, an_z, seg_z} !== {e.an, e.seg, e.an_z, e.seg_z}) begin
        failures++;
        $display("FAIL no_tear cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                 k, an, seg, e.an, e.seg);
      end
      if (k == 3) first = 4'd5;
    end
  endtask

  task automatic test_dash;
    restart(4'hC, 4'hF);
    push_n(OFF, BLK, OFF, BLK, 1);
    push_period(DASH, A1, DASH, A1, DASH);
    for (int k = 1; q.size() > 0; k++) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if ({an, seg, an_z, seg_z} !== {e.an, e.seg, e.an_z, e.seg_z}) begin
        failures++;
        $display("FAIL dash cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                 k, an, seg, e.an, e.seg);
      end
    end
  endtask

  task automatic test_reset_mid;
    restart(4'd6, 4'd2);
    push_n(OFF, BLK, OFF, BLK, 1);
    push_n(A0, S6, A0, S6, 4);
    push_n(OFF, BLK, OFF, BLK, 2);
    push_n(A1, S2, A1, S2, 3);
    for (int k = 1; q.size() > 0; k++) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if ({an, seg, an_z, seg_z} !== {e.an, e.seg, e.an_z, e.seg_z}) begin
        failures++;
        $display("FAIL reset_mid_pre cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                 k, an, seg, e.an, e.seg);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, an_z, seg_z} !== {OFF, BLK, 1'b1, OFF, BLK}) begin
      failures++;
      $display("FAIL reset_mid_async an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
               an, seg, dp, OFF, BLK);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_n(OFF, BLK, OFF, BLK, 1);
    push_n(A0, S6, A0, S6, 4);
    push_n(OFF, BLK, OFF, BLK, 2);
    for (int k = 1; q.size() > 0; k++) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if ({an, seg, an_z, seg_z} !== {e.an, e.seg, e.an_z, e.seg_z}) begin
        failures++;
        $display("FAIL reset_mid_post cyc=%0d got an=%b seg=%b want an=%b seg=%b",
                 k, an, seg, e.an, e.seg);
      end
    end
  endtask

  initial begin
    test_reset;
    test_leading_zero;
    test_no_tear;
    test_dash;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/two_digit_display.md
# two_digit_display

Downstream display stage for the two-digit BCD counter. Takes the counter's two 4-bit digit outputs and time-multiplexes them onto a 4-anode, common-anode seven-segment display. Each digit is shown in turn, with a blanking gap between digits to suppress ghosting. Optional leading-zero blanking applies to the tens digit, and non-BCD codes display as a dash.

## Interface
Parameters:
- REFRESH_DIV, default 100000: clock cycles each digit is lit. Must be ≥ 2.
- BLANK_CYCLES, default 16: clock cycles all anodes are off before each digit. Must be ≥ 1.
- LEADING_ZERO_BLANK, default 1: when 1, a tens digit of 0 is not lit.

Ports:
- two_digit_display_clk, in, 1: single clock.
- two_digit_display_rst, in, 1: reset, asynchronous, active-low.
- two_digit_display_first_num, in, 4: ones digit (rightmost, anode 0).
- two_digit_display_second_num, in, 4: tens digit (anode 1).
- two_digit_display_an, out, 4: anode enables, active-low. an[3:2] are always 1.
- two_digit_display_seg, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- two_digit_display_dp, out, 1: decimal point, active-low. Constant 1.

## Operation
- FSM states, cycling in this order: BLANK_0 → SHOW_0 → BLANK_1 → SHOW_1 → BLANK_0.
- A single down-counter times every state:
  - loaded with BLANK_CYCLES−1 on entering a BLANK state;
  - loaded with REFRESH_DIV−1 on entering a SHOW state;
  - the FSM advances on the edge where the counter is 0.
- Digit capture:
  - On the edge entering SHOW_0, first_num is latched into digit_q.
  - On the edge entering SHOW_1, second_num is latched into digit_q.
  - Input changes during a SHOW state have no effect until the next entry into that state. This prevents tearing.
- Decode of digit_q, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - 10–15 = 0111111 (dash)
- Anodes:
  - BLANK states: an = 1111, seg = 1111111.
  - SHOW_0: an = 1110.
  - SHOW_1: an = 1101.
  - SHOW_1 with LEADING_ZERO_BLANK = 1 and latched tens = 0: an = 1111 and seg = 1111111.
  - A dash in the tens position is never blanked.
- Reset (asynchronous, rst = 0):
  - state = BLANK_0, counter = BLANK_CYCLES−1, digit_q = 0;
  - an = 1111, seg = 1111111, dp = 1, all taking effect immediately with no clock required.

## Timing
- an and seg are registers loaded on the same edge as the state transition, so they are valid for exactly the cycles the FSM is in the corresponding state. There is no additional lag.
- After reset is released:
  - an = 1111 for BLANK_CYCLES rising edges;
  - an = 1110 from the BLANK_CYCLES-th edge for REFRESH_DIV cycles.
- Full refresh period is 2 × (REFRESH_DIV + BLANK_CYCLES) cycles.
- Exactly one anode is low in any cycle, or none during blanking.
- Input-to-display latency is at most one full period.
- Reset asserted mid-state aborts immediately. Operation restarts at BLANK_0 with a full blank interval.
- The counter width is $clog2(max(REFRESH_DIV, BLANK_CYCLES)). The counter must not wrap; a reload always occurs at 0.

## Structure
- Shared package two_digit_display_pkg holds:
  - state enum (BLANK_0, SHOW_0, BLANK_1, SHOW_1);
  - segment constants SEG_BLANK = 7'b1111111 and SEG_DASH = 7'b0111111;
  - AN_OFF = 4'b1111.
- Sub-module bcd_to_seg7: purely combinational 4-bit to 7-bit active-low decoder, including the dash for codes 10–15. It is instantiated once; the top registers its output.
- The top contains the FSM, the timing counter, digit capture and the anode/blanking logic.

## Test plan
All scenarios use REFRESH_DIV = 4 and BLANK_CYCLES = 2, giving a 12-cycle period.
1. Reset: hold rst = 0 → an = 1111, seg = 1111111, dp = 1 with no clock edge. Release → an = 1111 for 2 edges, then an = 1110 for 4 cycles, an = 1111 for 2, an = 1101 for 4, repeating.
2. first = 7, second = 4 → SHOW_0 gives an = 1110, seg = 1111000. SHOW_1 gives an = 1101, seg = 0011001.
3. second = 0 with LEADING_ZERO_BLANK = 1 → an = 1111 and seg = 1111111 throughout SHOW_1. Repeat with LEADING_ZERO_BLANK = 0 → an = 1101, seg = 1000000.
4. first changes 3 → 5 in the 2nd cycle of SHOW_0 → seg holds 0110000 to the end of that phase. The next SHOW_0 shows 0010010.
5. first = 4'hC, second = 4'hF → both phases show seg = 0111111. The tens digit is not blanked.
6. Assert rst in the 3rd cycle of SHOW_1 → an = 1111 and seg = 1111111 asynchronously. After release, 2 blank cycles, then SHOW_0 restarts.
